// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch, decode, execute,
// memory and write-back over one shared memory port, with access timeout and illegal-opcode flag.
module mips_multicycle_control #(
    parameter bit ENABLE_ANDI = 1'b1,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic       i_jr,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_illegal_op,
    output logic       o_bus_error,
    output logic [3:0] o_state
);

    // state | meaning: FETCH/MEMRD/MEMWR wait on memory; DECODE dispatches by opcode;
    // MEMADR/EXEC/BRANCH/IMMEX drive the ALU; MEMWB/ALUWB/IMMWB write registers; JUMP loads PC.
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IMMEX  = 4'd10;
    localparam logic [3:0] S_IMMWB  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_wait_state;
    logic             w_timeout;
    logic             w_legal;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout    = (MEM_TIMEOUT != 0) && w_wait_state && !i_mem_ready &&
                          (r_wait_cnt == TIMEOUT_C);
    assign o_state      = r_state;

    always_comb begin
        w_legal = 1'b0;
        case (i_opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: w_legal = 1'b1;
            OP_ANDI:                                       w_legal = ENABLE_ANDI;
            default:                                       w_legal = 1'b0;
        endcase
    end

    // Counter clears on every state change, so each wait state starts its count at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || w_timeout) begin
                r_wait_cnt <= '0;
            end else if (w_wait_state && !i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout)        w_next = S_FETCH;
                else if (i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_IMMEX;
                    OP_ANDI:      w_next = ENABLE_ANDI ? S_IMMEX : S_FETCH;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (w_timeout)        w_next = S_FETCH;
                else if (i_mem_ready) w_next = S_MEMWB;
            end
            S_MEMWR: begin
                if (w_timeout || i_mem_ready) w_next = S_FETCH;
            end
            S_EXEC:   w_next = i_jr ? S_FETCH : S_ALUWB;
            S_IMMEX:  w_next = S_IMMWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_alu_op        = 2'b00;
        o_pc_source     = 2'b00;
        o_illegal_op    = 1'b0;
        o_bus_error     = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b  = 2'b11;
                o_illegal_op = !w_legal;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = 2'b10;
                if (i_jr) begin
                    o_pc_source = 2'b11;
                    o_pc_write  = 1'b1;
                end
            end
            S_ALUWB: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = 2'b01;
                o_pc_write_cond = 1'b1;
                o_pc_source     = 2'b01;
            end
            S_JUMP: begin
                o_pc_source = 2'b10;
                o_pc_write  = 1'b1;
            end
            S_IMMEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_op    = (i_opcode == OP_ANDI) ? 2'b11 : 2'b00;
            end
            S_IMMWB: o_reg_write = 1'b1;
            default: ;
        endcase
        if (w_timeout) begin
            o_bus_error = 1'b1;
            o_mem_read  = 1'b0;
            o_mem_write = 1'b0;
            o_ir_write  = 1'b0;
            o_pc_write  = 1'b0;
        end
        // Reset suppresses every write so an interrupted instruction leaves no side effects.
        if (i_reset) begin
            o_pc_write      = 1'b0;
            o_pc_write_cond = 1'b0;
            o_mem_read      = 1'b0;
            o_mem_write     = 1'b0;
            o_ir_write      = 1'b0;
            o_reg_write     = 1'b0;
            o_illegal_op    = 1'b0;
            o_bus_error     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: two configurations share one stimulus stream,
// each checked every cycle against a table-driven behavioural model.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    wire  [21:0] obs_a;
    wire  [21:0] obs_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // A: andi legal, no timeout.  B: andi illegal, timeout after 4 wait cycles.
    mips_multicycle_control #(.ENABLE_ANDI(1'b1), .MEM_TIMEOUT(0), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_jr(jr), .i_mem_ready(mem_ready),
        .o_pc_write(obs_a[17]), .o_pc_write_cond(obs_a[16]), .o_iord(obs_a[15]),
        .o_mem_read(obs_a[14]), .o_mem_write(obs_a[13]), .o_ir_write(obs_a[12]),
        .o_mem_to_reg(obs_a[11]), .o_reg_dst(obs_a[10]), .o_reg_write(obs_a[9]),
        .o_alu_src_a(obs_a[8]), .o_alu_src_b(obs_a[7:6]), .o_alu_op(obs_a[5:4]),
        .o_pc_source(obs_a[3:2]), .o_illegal_op(obs_a[1]), .o_bus_error(obs_a[0]),
        .o_state(obs_a[21:18])
    );

    mips_multicycle_control #(.ENABLE_ANDI(1'b0), .MEM_TIMEOUT(4), .CNT_W(8)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_jr(jr), .i_mem_ready(mem_ready),
        .o_pc_write(obs_b[17]), .o_pc_write_cond(obs_b[16]), .o_iord(obs_b[15]),
        .o_mem_read(obs_b[14]), .o_mem_write(obs_b[13]), .o_ir_write(obs_b[12]),
        .o_mem_to_reg(obs_b[11]), .o_reg_dst(obs_b[10]), .o_reg_write(obs_b[9]),
        .o_alu_src_a(obs_b[8]), .o_alu_src_b(obs_b[7:6]), .o_alu_op(obs_b[5:4]),
        .o_pc_source(obs_b[3:2]), .o_illegal_op(obs_b[1]), .o_bus_error(obs_b[0]),
        .o_state(obs_b[21:18])
    );

    // Model: per-state fixed control word, then input-dependent adjustments.
    logic [17:0] base [12];
    int          m_st [2];
    int          m_wt [2];
    bit          m_ok [2];
    bit          andi_en [2] = '{1'b1, 1'b0};
    int          tmo [2]     = '{0, 4};

    // en = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, src_a}
    function automatic logic [17:0] mk(input logic [9:0] en, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic [1:0] ps);
        return {en, sb, aop, ps, 2'b00};
    endfunction

    function automatic bit legal(input int k, input logic [5:0] op);
        return (op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8}) || (op == 6'd12 && andi_en[k]);
    endfunction

    function automatic bit timed_out(input int k, input logic mr);
        return (m_st[k] inside {0, 3, 5}) && tmo[k] != 0 && m_wt[k] == tmo[k] && !mr;
    endfunction

    function automatic logic [21:0] expect_out(input int k, input logic rst, input logic [5:0] op,
                                               input logic j, input logic mr);
        logic [17:0] c;
        c = base[m_st[k]];
        if (m_st[k] == 0 && mr) begin c[17] = 1'b1; c[12] = 1'b1; end
        if (m_st[k] == 1 && !legal(k, op)) c[1] = 1'b1;
        if (m_st[k] == 6 && j) begin c[17] = 1'b1; c[3:2] = 2'b11; end
        if (m_st[k] == 10 && op == 6'd12) c[5:4] = 2'b11;
        if (timed_out(k, mr)) begin
            c[0] = 1'b1; c[17] = 1'b0; c[14] = 1'b0; c[13] = 1'b0; c[12] = 1'b0;
        end
        if (rst) begin
            c[17] = 1'b0; c[16] = 1'b0; c[14] = 1'b0; c[13] = 1'b0;
            c[12] = 1'b0; c[9] = 1'b0; c[1] = 1'b0; c[0] = 1'b0;
        end
        return {4'(m_st[k]), c};
    endfunction

    function automatic int next_st(input int k, input logic [5:0] op, input logic j, input logic mr);
        if (timed_out(k, mr)) return 0;
        case (m_st[k])
            0:  return mr ? 1 : 0;
            1: begin
                if (op == 6'd0)                        return 6;
                if (op == 6'd35 || op == 6'd43)        return 2;
                if (op == 6'd4)                        return 8;
                if (op == 6'd2)                        return 9;
                if (op == 6'd8 || (op == 6'd12 && andi_en[k])) return 10;
                return 0;
            end
            2:  return (op == 6'd35) ? 3 : 5;
            3:  return mr ? 4 : 3;
            5:  return mr ? 0 : 5;
            6:  return j ? 0 : 7;
            10: return 11;
            default: return 0;
        endcase
    endfunction

    function automatic logic [21:0] obs(input int k);
        return (k == 0) ? obs_a : obs_b;
    endfunction

    task automatic drive(input logic rst, input logic [5:0] op, input logic j, input logic mr);
        logic [21:0] exp_v;
        @(negedge clk);
        reset = rst; opcode = op; jr = j; mem_ready = mr;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (m_ok[k]) begin
                exp_v = expect_out(k, rst, op, j, mr);
                checks++;
                assert (obs(k) === exp_v) else begin
                    failures++;
                    $error("FAIL outputs_dut%0d: observed=%h expected=%h (op=%0d jr=%0b rdy=%0b rst=%0b)",
                           k, obs(k), exp_v, op, j, mr, rst);
                end
            end
        end
    endtask

    task automatic adv();
        int n [2];
        for (int k = 0; k < 2; k++) n[k] = next_st(k, opcode, jr, mem_ready);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_st[k] = 0; m_wt[k] = 0; m_ok[k] = 1'b1;
            end else begin
                if (n[k] != m_st[k] || timed_out(k, mem_ready)) m_wt[k] = 0;
                else if ((m_st[k] inside {0, 3, 5}) && !mem_ready) m_wt[k]++;
                m_st[k] = n[k];
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic [5:0] op, input logic j, input logic mr);
        drive(rst, op, j, mr);
        adv();
    endtask

    task automatic spot(input string tag, input logic [3:0] got, input logic [3:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    logic [5:0] op_r;
    logic [5:0] ops [10] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd12, 6'd13, 6'd63, 6'd0};

    initial begin
        base[0]  = mk(10'b0001000000, 2'b01, 2'b00, 2'b00);
        base[1]  = mk(10'b0000000000, 2'b11, 2'b00, 2'b00);
        base[2]  = mk(10'b0000000001, 2'b10, 2'b00, 2'b00);
        base[3]  = mk(10'b0011000000, 2'b00, 2'b00, 2'b00);
        base[4]  = mk(10'b0000001010, 2'b00, 2'b00, 2'b00);
        base[5]  = mk(10'b0010100000, 2'b00, 2'b00, 2'b00);
        base[6]  = mk(10'b0000000001, 2'b00, 2'b10, 2'b00);
        base[7]  = mk(10'b0000000110, 2'b00, 2'b00, 2'b00);
        base[8]  = mk(10'b0100000001, 2'b00, 2'b01, 2'b01);
        base[9]  = mk(10'b1000000000, 2'b00, 2'b00, 2'b10);
        base[10] = mk(10'b0000000001, 2'b10, 2'b00, 2'b00);
        base[11] = mk(10'b0000000010, 2'b00, 2'b00, 2'b00);
        m_ok = '{1'b0, 1'b0};
        reset = 1'b1; opcode = 6'd0; jr = 1'b0; mem_ready = 1'b0;

        cyc(1'b1, 6'd0, 1'b0, 1'b0);
        drive(1'b1, 6'd0, 1'b0, 1'b1);
        spot("reset_state", obs_a[21:18], 4'd0);
        spot("reset_no_read", {3'b0, obs_a[14]}, 4'd0);
        adv();

        // R-add
        drive(1'b0, 6'd0, 1'b0, 1'b1);
        spot("first_fetch_read", {3'b0, obs_a[14]}, 4'd1);
        adv();
        cyc(1'b0, 6'd0, 1'b0, 1'b1);
        drive(1'b0, 6'd0, 1'b0, 1'b1);
        spot("radd_exec_aluop", {2'b0, obs_a[5:4]}, 4'd2);
        adv();
        drive(1'b0, 6'd0, 1'b0, 1'b1);
        spot("radd_aluwb_state", obs_a[21:18], 4'd7);
        adv();
        drive(1'b0, 6'd35, 1'b0, 1'b1);
        spot("radd_back_fetch", obs_a[21:18], 4'd0);
        adv();

        // lw with three not-ready cycles in MEMRD
        cyc(1'b0, 6'd35, 1'b0, 1'b1);
        cyc(1'b0, 6'd35, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd35, 1'b0, 1'b0);
        drive(1'b0, 6'd35, 1'b0, 1'b1);
        spot("lw_memrd_held", obs_b[21:18], 4'd3);
        adv();
        drive(1'b0, 6'd35, 1'b0, 1'b1);
        spot("lw_memwb_m2r", {3'b0, obs_b[11]}, 4'd1);
        adv();

        // jr
        cyc(1'b0, 6'd0, 1'b1, 1'b1);
        cyc(1'b0, 6'd0, 1'b1, 1'b1);
        drive(1'b0, 6'd0, 1'b1, 1'b1);
        spot("jr_pc_source", {2'b0, obs_a[3:2]}, 4'd3);
        adv();
        drive(1'b0, 6'd4, 1'b0, 1'b1);
        spot("jr_no_aluwb", obs_a[21:18], 4'd0);
        adv();

        // beq
        cyc(1'b0, 6'd4, 1'b0, 1'b1);
        drive(1'b0, 6'd4, 1'b0, 1'b1);
        spot("beq_branch_state", obs_a[21:18], 4'd8);
        spot("beq_pcwc", {3'b0, obs_a[16]}, 4'd1);
        adv();

        // memory never ready in FETCH
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 6'd12, 1'b0, 1'b0);
            spot("tmo_no_irw", {2'b0, obs_b[12], obs_b[0]}, 4'd0);
            adv();
        end
        drive(1'b0, 6'd12, 1'b0, 1'b0);
        spot("tmo_bus_error", {3'b0, obs_b[0]}, 4'd1);
        adv();
        drive(1'b0, 6'd12, 1'b0, 1'b0);
        spot("tmo_refetch_clr", {obs_b[21:18] | {3'b0, obs_b[0]}}, 4'd0);
        adv();

        // andi: legal on A, illegal on B
        cyc(1'b0, 6'd12, 1'b0, 1'b1);
        drive(1'b0, 6'd12, 1'b0, 1'b1);
        spot("andi_illegal_b", {3'b0, obs_b[1]}, 4'd1);
        spot("andi_legal_a", {3'b0, obs_a[1]}, 4'd0);
        adv();
        cyc(1'b0, 6'd12, 1'b0, 1'b1);
        cyc(1'b0, 6'd12, 1'b0, 1'b1);

        // reset while a store waits in MEMWR
        cyc(1'b1, 6'd43, 1'b0, 1'b0);
        cyc(1'b0, 6'd43, 1'b0, 1'b1);
        cyc(1'b0, 6'd43, 1'b0, 1'b1);
        cyc(1'b0, 6'd43, 1'b0, 1'b1);
        cyc(1'b0, 6'd43, 1'b0, 1'b0);
        drive(1'b1, 6'd43, 1'b0, 1'b0);
        spot("rst_memwr_nowrite", {3'b0, obs_a[13]}, 4'd0);
        adv();
        drive(1'b0, 6'd43, 1'b0, 1'b0);
        spot("rst_memwr_fetch", obs_a[21:18], 4'd0);
        adv();

        for (int n = 0; n < 1500; n++) begin
            op_r = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op_r = 6'($urandom_range(0, 63));
            cyc(($urandom_range(0, 99) == 0), op_r, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
